// File: rtl/vending_input_conditioner.sv
// Input front-end for the vending machine: two-flop sync, counter debounce and press-edge
// pulses for coin/coffee/sprite, with coffee-over-sprite priority and busy gating.
module vending_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_coin,
  input  logic       raw_coffee,
  input  logic       raw_sprite,
  input  logic       i_busy,
  output logic       o_coin,
  output logic       o_coffee,
  output logic       o_sprite,
  output logic [2:0] o_level
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel bit order everywhere: {sprite, coffee, coin}
  logic [2:0]       raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [2:0]       stable_dly_q;
  logic [2:0]       rise;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign raw = {raw_sprite, raw_coffee, raw_coin};

  // Any return of sync to the debounced level restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = cnt_q[c];
      if (sync_q[c] == stable_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CntMax) begin
        stable_d[c] = sync_q[c];
        cnt_d[c]    = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= '0;
      end
      o_coin   <= 1'b0;
      o_coffee <= 1'b0;
      o_sprite <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync_q       <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int c = 0; c < 3; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      o_coin   <= rise[0];
      o_coffee <= rise[1] & ~i_busy;
      // Coffee wins a same-cycle tie; the losing sprite request is dropped.
      o_sprite <= rise[2] & ~rise[1] & ~i_busy;
    end
  end

  assign o_level = stable_q;

endmodule

// File: doc/vending_input_conditioner.md
# vending_input_conditioner

Front-end for the vending machine: synchronises, debounces and edge-detects the raw coin-acceptor and product-button switch lines. It emits the single-cycle `i_coin`, `i_coffee` and `i_sprite` request pulses consumed by the vending FSM. Product requests are arbitrated against each other and gated off while the machine is dispensing. It sits between the board pins and the vending machine top level.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive cycles a synchronised input must differ from its debounced state before the change is accepted. Legal values are 2 or more.
- `CNT_W`, default 18: width of each debounce counter. It must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `raw_coin` in 1: coin switch, asynchronous, active-high, may bounce.
- `raw_coffee` in 1: coffee button, asynchronous, active-high, may bounce.
- `raw_sprite` in 1: sprite button, asynchronous, active-high, may bounce.
- `i_busy` in 1: synchronous; high while the FSM is dispensing (its `o_coffee | o_sprite`).
- `o_coin` out 1: one-cycle pulse per accepted coin insertion.
- `o_coffee` out 1: one-cycle pulse per accepted coffee request.
- `o_sprite` out 1: one-cycle pulse per accepted sprite request.
- `o_level` out 3: debounced levels `{sprite, coffee, coin}`, for LEDs and debug.

## Operation
Each of the three channels is identical.

- **Synchroniser:** a two-flop synchroniser produces `sync`.
- **Debounce state:** each channel holds a debounced register `stable` and a counter `cnt`.
- **Debounce, every cycle:**
  - If `sync == stable`, then `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync` and `cnt <= 0`.
  - Else, `cnt <= cnt+1`.
- **Glitch rejection:** any return of `sync` to `stable` before the count completes restarts the count. A pulse shorter than DEBOUNCE_CYCLES cycles therefore never changes `stable`.
- **Edge detect:** a registered copy `stable_d` produces `rise = stable & ~stable_d`. Only press edges (0→1) generate pulses; release edges generate nothing.
- **Output registers:** outputs are registered from `rise`, as follows:
  - `o_coin <= rise_coin`. Coin is never gated.
  - `o_coffee <= rise_coffee & ~i_busy`.
  - `o_sprite <= rise_sprite & ~rise_coffee & ~i_busy`. If both product rises occur on the same cycle, coffee wins and the sprite request is discarded.
- **Dropped requests:** gated or discarded requests are dropped, not queued. A held button does not re-trigger; it must be released (debounced) and pressed again.
- **Concurrency:** a coin pulse may coincide with a product pulse.
- **`o_level`:** equals `{stable_sprite, stable_coffee, stable_coin}`.

## Timing
- **Reset values:** `sync` flops, `stable`, `stable_d`, `cnt` and all outputs are 0.
- **Reset mid-operation:** a partial debounce count is discarded immediately.
- **Input held high across reset release:** it is treated as a new press. A pulse follows after the full latency below.
- **Latency:** take the first rising edge that samples a clean raw high as edge 1.
  - `sync` is high after edge 2.
  - `stable` sets at edge DEBOUNCE_CYCLES+2.
  - The output pulse is high from edge DEBOUNCE_CYCLES+3 to edge DEBOUNCE_CYCLES+4.
  - Total latency is DEBOUNCE_CYCLES+2 cycles.
- **Release latency:** identical to press latency, but no pulse is produced.
- **`i_busy` sampling:** `i_busy` is sampled on the same edge that registers the product pulse, with no extra latency.
- **Pulse width:** every pulse is exactly one cycle wide, and there is at most one pulse per channel per press.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.

1. **Clean coin press:** drive `raw_coin` high and hold for 20 cycles → `o_coin` is high for exactly one cycle, 6 cycles after the first sampling edge. `o_level[0]` is 1 and stays 1; no further pulses occur.
2. **Bounce rejection:** toggle `raw_coffee` 1,0,1,0 every 2 cycles, then hold high → no pulse during the bounce. Exactly one `o_coffee` pulse occurs, 6 cycles after the final rising edge.
3. **Glitch:** drive a 3-cycle-wide high on `raw_sprite` → no `o_sprite` pulse, and `o_level[2]` stays 0.
4. **Arbitration:** raise `raw_coffee` and `raw_sprite` on the same edge with `i_busy=0` → one `o_coffee` pulse and no `o_sprite` pulse. Both `o_level` bits become 1.
5. **Busy gating:**
   - Hold `i_busy=1` while coffee and coin presses mature → `o_coin` pulses and `o_coffee` does not.
   - Then drop `i_busy` while the button is still held → still no `o_coffee` pulse.
   - Release and press again → `o_coffee` pulses.
6. **Reset mid-count:** assert `rst_n=0` for 1 cycle, 3 cycles into a coin debounce, with `raw_coin` still high → all outputs are 0 during reset. The count restarts, and `o_coin` pulses 6 cycles after the first post-reset edge.
